// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared mini MIPS constants, fetch state enum and opcode helper
package mips_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    HALTED  = 2'd3
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction handshake between fetch unit and datapath
interface instr_fetch_unit_if;
  import mips_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);

endinterface

// File: rtl/instr_fetch_unit_imem.sv
// rtl/instr_fetch_unit_imem.sv - program memory, one sync write port and one async read port
module imem
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  // Deliberately not reset so a program survives a restart.
  logic [INSTR_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM, program counter and accepted-instruction counter
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [INSTR_W-1:0]  load_data,
  input  logic                start,
  instr_fetch_unit_if.master  fetch,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         instr_count
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        count_q, count_d;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_rdata;

  // Loads are only honoured while no program is running.
  assign mem_we = load_en && ((state_q == IDLE) || (state_q == HALTED));

  imem #(.ADDR_W(ADDR_W)) u_imem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = READ;
          pc_d    = '0;
          count_d = '0;
        end
      end
      READ: begin
        instr_d = mem_rdata;
        // A HALT word is captured but never presented; pc keeps pointing at it.
        state_d = (opcode_of(mem_rdata) == HALT_OP) ? HALTED : PRESENT;
      end
      PRESENT: begin
        if (fetch.instr_ready) begin
          pc_d    = pc_q + 1'b1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch.instr_valid = (state_q == PRESENT);
    busy              = (state_q == READ) || (state_q == PRESENT);
    halted            = (state_q == HALTED);
  end

  assign fetch.instr  = instr_q;
  assign pc           = pc_q;
  assign instr_count  = count_q;

endmodule
